// File: rtl/ma_mem_responder.sv
// MA-stage data-memory responder: one byte/half/word access at a time
// against a word-organised little-endian RAM, with rack/wack handshake.
module ma_mem_responder #(
  parameter int MADDR_L   = 32,
  parameter int DATA_L    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               co_re,
  input  logic [1:0]         co_rlen,
  input  logic [MADDR_L-1:0] m_raddr,
  input  logic               co_we,
  input  logic [1:0]         co_wlen,
  input  logic [MADDR_L-1:0] m_waddr,
  input  logic [DATA_L-1:0]  mem_out,
  output logic [DATA_L-1:0]  mem_in,
  output logic               co_rack,
  output logic               co_wack,
  output logic               busy,
  output logic               err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_ACK,
    S_WR_ACK,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [1:0]        rlen_q, rlen_d;
  logic              err_q, err_d;
  logic [DATA_L-1:0] mem_in_q, mem_in_d;

  logic [DATA_L-1:0] mem_q [MEM_WORDS];

  logic [AW-1:0]     rd_addr;
  logic [1:0]        rd_len;
  logic              rd_bad;
  logic [DATA_L-1:0] rd_word, rd_sh, rd_data;

  logic [AW-1:0]     wr_addr;
  logic              wr_bad;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [DATA_L-1:0] wr_sh, wr_old, wr_word_d;

  logic unused_hi;
  assign unused_hi = ^{m_raddr[MADDR_L-1:AW], m_waddr[MADDR_L-1:AW]};

  function automatic logic bad_acc(input logic [1:0] lane,
                                   input logic [1:0] len);
    return (len == 2'b10) ||
           (len == 2'b01 && lane[0]) ||
           (len == 2'b11 && lane != 2'b00);
  endfunction

  // In IDLE the read is taken straight from the port so RD_LAT=1 works
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? m_raddr[AW-1:0] : raddr_q;
    rd_len  = (state_q == S_IDLE) ? co_rlen : rlen_q;
    rd_bad  = bad_acc(rd_addr[1:0], rd_len);
    rd_word = mem_q[rd_addr[AW-1:2]];
    rd_sh   = rd_word >> {rd_addr[1:0], 3'b000};
    rd_data = '0;
    unique case (rd_len)
      2'b00:   rd_data = DATA_L'(rd_sh[7:0]);
      2'b01:   rd_data = DATA_L'(rd_sh[15:0]);
      2'b11:   rd_data = rd_sh;
      default: rd_data = '0;
    endcase
    if (rd_bad) rd_data = '0;
  end

  always_comb begin
    wr_addr = m_waddr[AW-1:0];
    wr_bad  = bad_acc(wr_addr[1:0], co_wlen);
    wr_en   = !rst && state_q == S_IDLE && co_we;
    wr_be   = 4'b0000;
    unique case (co_wlen)
      2'b00:   wr_be = 4'b0001 << wr_addr[1:0];
      2'b01:   wr_be = 4'b0011 << wr_addr[1:0];
      2'b11:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
    if (wr_bad) wr_be = 4'b0000;
    wr_sh     = mem_out << {wr_addr[1:0], 3'b000};
    wr_old    = mem_q[wr_addr[AW-1:2]];
    wr_word_d = wr_old;
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) wr_word_d[8*k +: 8] = wr_sh[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr[AW-1:2]] <= wr_word_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    err_d    = err_q;
    mem_in_d = mem_in_q;
    unique case (state_q)
      S_IDLE: begin
        if (co_we) begin
          err_d   = wr_bad;
          state_d = S_WR_ACK;
        end else if (co_re) begin
          raddr_d = m_raddr[AW-1:0];
          rlen_d  = co_rlen;
          err_d   = rd_bad;
          cnt_d   = CNT_W'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            mem_in_d = rd_data;
            state_d  = S_RD_ACK;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          mem_in_d = rd_data;
          state_d  = S_RD_ACK;
        end
      end
      S_RD_ACK: state_d = S_HOLD;
      S_WR_ACK: state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      err_q    <= 1'b0;
      mem_in_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      err_q    <= err_d;
      mem_in_q <= mem_in_d;
    end
  end

  assign co_rack = (state_q == S_RD_ACK);
  assign co_wack = (state_q == S_WR_ACK);
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q && (co_rack || co_wack);
  assign mem_in  = mem_in_q;

endmodule

// File: tb/tb_ma_mem_responder.sv
// Scoreboard bench for ma_mem_responder: RD_LAT=1 and RD_LAT=3 instances
// against a byte-array reference memory.
module tb_ma_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  co_re = '0;
  logic [1:0]  co_we = '0;
  logic [1:0]  co_rlen [2];
  logic [1:0]  co_wlen [2];
  logic [31:0] m_raddr [2];
  logic [31:0] m_waddr [2];
  logic [31:0] mem_out [2];
  logic [31:0] mem_in  [2];
  logic [1:0]  co_rack, co_wack, busy, err;

  always #5 clk = ~clk;

  ma_mem_responder #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .co_re(co_re[0]), .co_rlen(co_rlen[0]), .m_raddr(m_raddr[0]),
    .co_we(co_we[0]), .co_wlen(co_wlen[0]), .m_waddr(m_waddr[0]),
    .mem_out(mem_out[0]), .mem_in(mem_in[0]),
    .co_rack(co_rack[0]), .co_wack(co_wack[0]),
    .busy(busy[0]), .err(err[0])
  );

  ma_mem_responder #(.RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .co_re(co_re[1]), .co_rlen(co_rlen[1]), .m_raddr(m_raddr[1]),
    .co_we(co_we[1]), .co_wlen(co_wlen[1]), .m_waddr(m_waddr[1]),
    .mem_out(mem_out[1]), .mem_in(mem_in[1]),
    .co_rack(co_rack[1]), .co_wack(co_wack[1]),
    .busy(busy[1]), .err(err[1])
  );

  typedef struct {
    int          d;
    bit          wr;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  rmem [2][4096];
  logic [31:0] last_rd [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rdl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit illegal(input logic [31:0] a, input logic [1:0] len);
    return (len == 2'b10) || ((a % nbytes(len)) != 0);
  endfunction

  function automatic void mdl_write(input int d, input logic [31:0] a,
      input logic [1:0] len, input logic [31:0] wd, output bit e);
    int b;
    e = illegal(a, len);
    b = int'(a[11:0]);
    if (!e)
      for (int i = 0; i < nbytes(len); i++) rmem[d][b + i] = wd[8*i +: 8];
  endfunction

  function automatic void mdl_read(input int d, input logic [31:0] a,
      input logic [1:0] len, output bit e, output logic [31:0] v);
    int b;
    e = illegal(a, len);
    b = int'(a[11:0]);
    v = '0;
    if (!e)
      for (int i = 0; i < nbytes(len); i++) v[8*i +: 8] = rmem[d][b + i];
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cyc%0d: got %h want %h", nm, d, cyc, got, want);
    end
  endtask

  task automatic monitor();
    bit prev [2] = '{0, 0};
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (co_rack[d] || co_wack[d]) begin
            chk("ack_width", d, 32'(prev[d]), 0);
            chk("busy_at_ack", d, 32'(busy[d]), 1);
            chk("ack_both", d, 32'(co_rack[d] && co_wack[d]), 0);
            if (sb.size() == 0) begin
              chk("unexpected_ack", d, 1, 0);
            end else begin
              e = sb.pop_front();
              chk("ack_dut", d, 32'(d), 32'(e.d));
              chk("ack_kind", d, 32'(co_wack[d]), 32'(e.wr));
              chk("ack_cycle", d, 32'(cyc), 32'(e.cyc));
              chk("err", d, 32'(err[d]), 32'(e.err));
              if (!e.wr) begin
                chk("rdata", d, mem_in[d], e.data);
                last_rd[d] = e.data;
              end
            end
          end else begin
            chk("err_idle", d, 32'(err[d]), 0);
            chk("mem_in_hold", d, mem_in[d], last_rd[d]);
          end
          prev[d] = co_rack[d] || co_wack[d];
        end
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", d, 32'(busy[d]), 0);
  endtask

  task automatic wait_ack(input int d, input bit wr);
    int n = 0;
    bit got;
    do begin
      @(posedge clk); #1;
      n++;
      got = wr ? co_wack[d] : co_rack[d];
    end while (!got && n < 20);
    chk(wr ? "wack_timeout" : "rack_timeout", d, 32'(got), 1);
    if (wr) co_we[d] = 1'b0;
    else    co_re[d] = 1'b0;
  endtask

  task automatic drive_w(input int d, input logic [31:0] a,
                         input logic [1:0] len, input logic [31:0] wd);
    co_we[d] = 1'b1; m_waddr[d] = a; co_wlen[d] = len; mem_out[d] = wd;
  endtask

  task automatic drive_r(input int d, input logic [31:0] a,
                         input logic [1:0] len);
    co_re[d] = 1'b1; m_raddr[d] = a; co_rlen[d] = len;
  endtask

  task automatic access(input int d, input bit wr, input logic [31:0] a,
                        input logic [1:0] len, input logic [31:0] wd);
    exp_t e;
    bit eb;
    logic [31:0] v;
    wait_idle(d);
    e.d = d; e.wr = wr;
    if (wr) begin
      mdl_write(d, a, len, wd, eb);
      e.err = eb; e.data = '0; e.cyc = cyc + 1;
      drive_w(d, a, len, wd);
    end else begin
      mdl_read(d, a, len, eb, v);
      e.err = eb; e.data = v; e.cyc = cyc + rdl(d);
      drive_r(d, a, len);
    end
    sb.push_back(e);
    wait_ack(d, wr);
  endtask

  // Both levels raised together: write first, read accepted after HOLD
  task automatic both(input int d, input logic [31:0] a, input logic [31:0] wd);
    exp_t ew, er;
    bit eb;
    logic [31:0] v;
    wait_idle(d);
    mdl_write(d, a, 2'b11, wd, eb);
    ew.d = d; ew.wr = 1; ew.err = eb; ew.data = '0; ew.cyc = cyc + 1;
    mdl_read(d, a, 2'b11, eb, v);
    er.d = d; er.wr = 0; er.err = eb; er.data = v; er.cyc = cyc + 3 + rdl(d);
    sb.push_back(ew);
    sb.push_back(er);
    drive_w(d, a, 2'b11, wd);
    drive_r(d, a, 2'b11);
    wait_ack(d, 1);
    wait_ack(d, 0);
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [31:0] a;
    logic [1:0]  len;
    int r;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      a[11:8] = 4'h0;
      r = int'($urandom_range(0, 7));
      len = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10;
      access(d, $urandom_range(0, 1) == 1, a, len, $urandom);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      co_rlen[d] = '0; co_wlen[d] = '0;
      m_raddr[d] = '0; m_waddr[d] = '0; mem_out[d] = '0;
      last_rd[d] = '0;
    end
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mem_in", d, mem_in[d], 0);
      chk("rst_ctl", d, {28'd0, co_rack[d], co_wack[d], busy[d], err[d]}, 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        access(d, 1, 32'(w * 4), 2'b11, $urandom);

    access(0, 1, 32'h10, 2'b11, 32'hDEADBEEF);
    access(0, 0, 32'h10, 2'b11, 0);
    access(0, 1, 32'h13, 2'b00, 32'h000000AA);
    access(0, 0, 32'h10, 2'b11, 0);
    access(0, 0, 32'h12, 2'b00, 0);
    access(0, 0, 32'h12, 2'b01, 0);
    access(0, 1, 32'h11, 2'b01, 32'h00005555);
    access(0, 0, 32'h10, 2'b10, 0);
    access(0, 0, 32'h10, 2'b11, 0);
    both(0, 32'h20, 32'h12345678);
    access(0, 1, 32'h1004, 2'b11, 32'hCAFEF00D);
    access(0, 0, 32'h0004, 2'b11, 0);
    rand_ops(0, 150);

    // Reset while the RD_LAT=3 instance sits in RD_WAIT
    wait_idle(1);
    drive_r(1, 32'h10, 2'b11);
    @(posedge clk); #1;
    chk("rdwait_busy", 1, 32'(busy[1]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mem_in", 1, mem_in[1], 0);
    chk("mid_rst_ctl", 1, {28'd0, co_rack[1], co_wack[1], busy[1], err[1]}, 0);
    rst = 1'b0;
    co_re[1] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (6) @(posedge clk);
    #1;
    access(1, 1, 32'h10, 2'b11, 32'hDEADBEEF);
    access(1, 0, 32'h10, 2'b11, 0);
    access(1, 1, 32'h11, 2'b01, 32'h00001234);
    access(1, 0, 32'h13, 2'b00, 0);
    both(1, 32'h20, 32'h12345678);
    access(1, 1, 32'h1004, 2'b11, 32'h0BADCAFE);
    access(1, 0, 32'h0004, 2'b11, 0);
    rand_ops(1, 150);

    repeat (6) @(posedge clk);
    chk("sb_drained", 0, 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
